// File: rtl/debug_bridge.sv
// Byte-command debug bridge: decodes UART bytes into output-word writes, input-word reads,
// divider/mode control and N-cycle single-step of the core clock-enable.
module debug_bridge #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_OUT = 4,
  parameter int NUM_IN = 2,
  parameter int COUNTER_BITS = 32,
  parameter logic [COUNTER_BITS-1:0] INIT_DIVIDER = COUNTER_BITS'(32'h0000FFFF)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx_valid,
  input  logic [7:0]                    rx_data,
  output logic [7:0]                    tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic [NUM_OUT*DATA_WIDTH-1:0] out_bus,
  input  logic [NUM_IN*DATA_WIDTH-1:0]  in_bus,
  output logic                          core_clk_en,
  output logic                          busy,
  output logic                          err,
  output logic [2:0]                    dbg_state
);

  // Handshake: rx_valid is a one-cycle strobe with no back-pressure (bytes seen while busy are
  // dropped); a tx byte is transferred on a clock edge with tx_valid & tx_ready, and tx_data/tx_valid
  // hold until then.

  localparam int BPW   = DATA_WIDTH / 8;
  localparam int DMAX  = (DATA_WIDTH > 32) ? DATA_WIDTH : 32;
  localparam int CW    = $clog2(DMAX / 8);
  localparam int LW    = $clog2(BPW + 1);
  localparam int OW    = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
  localparam int IW    = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  localparam logic [7:0] OP_WR   = 8'h01;
  localparam logic [7:0] OP_RD   = 8'h02;
  localparam logic [7:0] OP_DIV  = 8'h03;
  localparam logic [7:0] OP_MODE = 8'h04;
  localparam logic [7:0] OP_STEP = 8'h05;
  localparam logic [7:0] ACK     = 8'hAA;
  localparam logic [7:0] NAK     = 8'hEE;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_GET_IDX  = 3'd1,
    S_GET_ARG  = 3'd2,
    S_GET_DATA = 3'd3,
    S_EXEC     = 3'd4,
    S_STEP     = 3'd5,
    S_SEND     = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    M_HALT = 2'd0,
    M_RUN  = 2'd1,
    M_DIV  = 2'd2
  } mode_t;

  state_t                  r_state;
  mode_t                   r_mode;
  logic [7:0]              r_op;
  logic [7:0]              r_idx;
  logic [7:0]              r_arg;
  logic [DMAX-1:0]         r_data;
  logic [CW-1:0]           r_cnt;
  logic [CW-1:0]           r_last;
  logic [DATA_WIDTH-1:0]   r_out [NUM_OUT];
  logic [COUNTER_BITS-1:0] r_divider;
  logic [COUNTER_BITS-1:0] r_div_cnt;
  logic                    r_clk_en;
  logic [7:0]              r_step_left;
  logic [7:0]              r_tx_data;
  logic                    r_tx_valid;
  logic [DATA_WIDTH-1:0]   r_tx_shift;
  logic [LW-1:0]           r_tx_left;
  logic                    r_err;

  logic [DATA_WIDTH-1:0]   w_in_words [NUM_IN];
  logic [DATA_WIDTH-1:0]   w_wr_word;
  logic [DATA_WIDTH-1:0]   w_rd_word;
  logic [31:0]             w_div_word;
  logic [COUNTER_BITS-1:0] w_div_val;
  logic                    w_out_ok;
  logic                    w_in_ok;
  logic                    w_nak;

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
    assign out_bus[g*DATA_WIDTH +: DATA_WIDTH] = r_out[g];
  end

  for (genvar g = 0; g < NUM_IN; g++) begin : g_in
    assign w_in_words[g] = in_bus[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Little-endian fields shift in from the top, so after N bytes the value sits in the top N bytes.
  assign w_wr_word  = r_data[DMAX-1 -: DATA_WIDTH];
  assign w_div_word = r_data[DMAX-1 -: 32];
  assign w_rd_word  = w_in_words[r_idx[IW-1:0]];
  assign w_out_ok   = ({1'b0, r_idx} < 9'(NUM_OUT));
  assign w_in_ok    = ({1'b0, r_idx} < 9'(NUM_IN));

  if (COUNTER_BITS <= 32) begin : g_div_narrow
    assign w_div_val = w_div_word[COUNTER_BITS-1:0];
  end else begin : g_div_wide
    assign w_div_val = {{(COUNTER_BITS-32){1'b0}}, w_div_word};
  end

  always_comb begin
    w_nak = 1'b0;
    case (r_op)
      OP_WR:   w_nak = !w_out_ok;
      OP_RD:   w_nak = !w_in_ok;
      OP_DIV:  w_nak = 1'b0;
      OP_MODE: w_nak = (r_arg > 8'd2);
      OP_STEP: w_nak = (r_mode != M_HALT);
      default: w_nak = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_mode      <= M_HALT;
      r_op        <= 8'd0;
      r_idx       <= 8'd0;
      r_arg       <= 8'd0;
      r_data      <= '0;
      r_cnt       <= '0;
      r_last      <= '0;
      for (int k = 0; k < NUM_OUT; k++) r_out[k] <= '0;
      r_divider   <= INIT_DIVIDER;
      r_div_cnt   <= '0;
      r_clk_en    <= 1'b0;
      r_step_left <= 8'd0;
      r_tx_data   <= 8'd0;
      r_tx_valid  <= 1'b0;
      r_tx_shift  <= '0;
      r_tx_left   <= '0;
      r_err       <= 1'b0;
    end else begin
      r_err    <= 1'b0;
      r_clk_en <= 1'b0;
      case (r_mode)
        M_RUN: r_clk_en <= 1'b1;
        M_DIV: begin
          if (r_div_cnt == r_divider) begin
            r_clk_en  <= 1'b1;
            r_div_cnt <= '0;
          end else begin
            r_div_cnt <= r_div_cnt + COUNTER_BITS'(1);
          end
        end
        default: ;
      endcase

      case (r_state)
        S_IDLE: begin
          if (rx_valid) begin
            r_op  <= rx_data;
            r_cnt <= '0;
            case (rx_data)
              OP_WR, OP_RD:      r_state <= S_GET_IDX;
              OP_MODE, OP_STEP:  r_state <= S_GET_ARG;
              OP_DIV: begin
                r_state <= S_GET_DATA;
                r_last  <= CW'(3);
              end
              default: begin
                r_state    <= S_SEND;
                r_tx_data  <= NAK;
                r_tx_valid <= 1'b1;
                r_tx_left  <= LW'(1);
                r_err      <= 1'b1;
              end
            endcase
          end
        end
        S_GET_IDX: begin
          if (rx_valid) begin
            r_idx <= rx_data;
            if (r_op == OP_WR) begin
              r_state <= S_GET_DATA;
              r_last  <= CW'(BPW - 1);
            end else begin
              r_state <= S_EXEC;
            end
          end
        end
        S_GET_ARG: begin
          if (rx_valid) begin
            r_arg   <= rx_data;
            r_state <= S_EXEC;
          end
        end
        S_GET_DATA: begin
          if (rx_valid) begin
            r_data <= {rx_data, r_data[DMAX-1:8]};
            r_cnt  <= r_cnt + CW'(1);
            if (r_cnt == r_last) r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_state    <= S_SEND;
          r_tx_valid <= 1'b1;
          r_tx_left  <= LW'(1);
          r_tx_data  <= ACK;
          if (w_nak) begin
            r_tx_data <= NAK;
            r_err     <= 1'b1;
          end else begin
            case (r_op)
              OP_WR: r_out[r_idx[OW-1:0]] <= w_wr_word;
              OP_RD: begin
                // Snapshot makes the reply atomic even if in_bus moves mid-reply.
                r_tx_data  <= w_rd_word[7:0];
                r_tx_shift <= w_rd_word >> 8;
                r_tx_left  <= LW'(BPW);
              end
              OP_DIV: begin
                r_divider <= w_div_val;
                r_div_cnt <= '0;
              end
              OP_MODE: begin
                r_mode    <= mode_t'(r_arg[1:0]);
                r_div_cnt <= '0;
              end
              OP_STEP: begin
                if (r_arg != 8'd0) begin
                  r_state     <= S_STEP;
                  r_tx_valid  <= 1'b0;
                  r_clk_en    <= 1'b1;
                  r_step_left <= r_arg - 8'd1;
                end
              end
              default: ;
            endcase
          end
        end
        S_STEP: begin
          if (r_step_left != 8'd0) begin
            r_clk_en    <= 1'b1;
            r_step_left <= r_step_left - 8'd1;
          end else begin
            r_state    <= S_SEND;
            r_tx_valid <= 1'b1;
            r_tx_data  <= ACK;
            r_tx_left  <= LW'(1);
          end
        end
        S_SEND: begin
          if (tx_ready) begin
            if (r_tx_left > LW'(1)) begin
              r_tx_data  <= r_tx_shift[7:0];
              r_tx_shift <= r_tx_shift >> 8;
              r_tx_left  <= r_tx_left - LW'(1);
            end else begin
              r_tx_valid <= 1'b0;
              r_state    <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tx_data     = r_tx_data;
  assign tx_valid    = r_tx_valid;
  assign core_clk_en = r_clk_en;
  assign err         = r_err;
  assign busy        = (r_state == S_EXEC) || (r_state == S_STEP) || (r_state == S_SEND);
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_debug_bridge.sv
// Bench for debug_bridge: directed scenarios plus random commands, with a reply scoreboard
// fed by a command-level model and a monitor that pops on every tx handshake.
module tb_debug_bridge;
  localparam int DW = 32;
  localparam int NO = 4;
  localparam int NI = 2;
  localparam int CB = 32;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             rx_valid = 1'b0;
  logic [7:0]       rx_data = 8'd0;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready = 1'b0;
  logic [NO*DW-1:0] out_bus;
  logic [NI*DW-1:0] in_bus;
  logic             core_clk_en;
  logic             busy;
  logic             err;
  logic [2:0]       dbg_state;

  debug_bridge #(
    .DATA_WIDTH(DW), .NUM_OUT(NO), .NUM_IN(NI), .COUNTER_BITS(CB), .INIT_DIVIDER(32'h0000FFFF)
  ) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .out_bus(out_bus), .in_bus(in_bus), .core_clk_en(core_clk_en),
    .busy(busy), .err(err), .dbg_state(dbg_state)
  );

  initial forever #5 clk = ~clk;

  // Reference state and scoreboard
  logic [7:0]  exp_q[$];
  logic [7:0]  cmd_q[$];
  logic [31:0] m_out [NO];
  logic [31:0] m_in [NI];
  int          m_mode;
  logic [31:0] m_div;
  int          n_checks = 0;
  int          n_fail = 0;
  int          err_seen = 0;
  int          err_exp = 0;
  int          exp_pulses = -1;
  int          en_cnt = 0;
  int          en_first = -1;
  int          en_last = -1;
  int          cyc = 0;
  bit          log_pulses = 1'b0;
  int          pulse_q[$];
  int          ready_mode = 0;
  bit          held = 1'b0;
  logic [7:0]  held_data;
  logic [7:0]  e_byte;

  assign in_bus = {m_in[1], m_in[0]};

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NO*DW-1:0] exp_bus();
    logic [NO*DW-1:0] r;
    for (int k = 0; k < NO; k++) r[k*DW +: DW] = m_out[k];
    return r;
  endfunction

  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = 1'($urandom_range(0, 1));
      default: tx_ready = 1'b0;
    endcase
  end

  // Monitor: samples on the falling edge, pops expected bytes on each handshake
  initial forever begin
    @(negedge clk);
    cyc++;
    if (!reset) begin
      held = 1'b0;
    end else begin
      if (core_clk_en) begin
        en_cnt++;
        if (en_first < 0) en_first = cyc;
        en_last = cyc;
        if (log_pulses) pulse_q.push_back(cyc);
      end
      if (err) err_seen++;
      if (tx_valid) begin
        if (held) check("tx_hold", tx_data, held_data);
        if (tx_ready) begin
          held = 1'b0;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL tx_unexpected: got %02h expected no byte", tx_data);
          end else begin
            e_byte = exp_q.pop_front();
            check("tx_byte", tx_data, e_byte);
          end
        end else begin
          held = 1'b1;
          held_data = tx_data;
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_valid = 1'b1;
    rx_data = b;
    tick();
    rx_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic push_nak();
    exp_q.push_back(8'hEE);
    err_exp++;
  endtask

  task automatic model_cmd();
    int idx;
    exp_pulses = -1;
    case (cmd_q[0])
      8'h01: begin
        idx = int'(cmd_q[1]);
        if (idx < NO) begin
          m_out[idx] = {cmd_q[5], cmd_q[4], cmd_q[3], cmd_q[2]};
          exp_q.push_back(8'hAA);
        end else push_nak();
      end
      8'h02: begin
        idx = int'(cmd_q[1]);
        if (idx < NI) for (int b = 0; b < 4; b++) exp_q.push_back(m_in[idx][8*b +: 8]);
        else push_nak();
      end
      8'h03: begin
        m_div = {cmd_q[4], cmd_q[3], cmd_q[2], cmd_q[1]};
        exp_q.push_back(8'hAA);
      end
      8'h04: begin
        if (cmd_q[1] <= 8'd2) begin
          m_mode = int'(cmd_q[1]);
          exp_q.push_back(8'hAA);
        end else push_nak();
      end
      8'h05: begin
        if (m_mode == 0) begin
          exp_pulses = int'(cmd_q[1]);
          exp_q.push_back(8'hAA);
        end else push_nak();
      end
      default: push_nak();
    endcase
  endtask

  task automatic issue_cmd();
    model_cmd();
    en_cnt = 0;
    en_first = -1;
    en_last = -1;
    for (int i = 0; i < cmd_q.size(); i++)
      send_byte(cmd_q[i], (i == cmd_q.size() - 1) ? 0 : int'($urandom_range(0, 2)));
  endtask

  task automatic wait_done();
    int t = 0;
    while ((exp_q.size() != 0 || busy || tx_valid) && t < 3000) begin
      tick();
      t++;
    end
    if (t >= 3000) begin
      n_checks++;
      n_fail++;
      $display("FAIL reply_timeout: got %0d bytes outstanding expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic finish_cmd();
    wait_done();
    check("tx_idle", tx_valid, 1'b0);
    check("err_count", err_seen, err_exp);
    check("out_bus", out_bus, exp_bus());
    if (exp_pulses >= 0) begin
      check("step_pulses", en_cnt, exp_pulses);
      if (exp_pulses > 0) check("step_span", en_last - en_first + 1, exp_pulses);
    end
  endtask

  task automatic run_cmd();
    issue_cmd();
    finish_cmd();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_clk_en", core_clk_en, 1'b0);
    check("rst_out_bus", out_bus, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    reset = 1'b1;
    for (int k = 0; k < NO; k++) m_out[k] = '0;
    m_mode = 0;
    m_div = 32'h0000FFFF;
    exp_q.delete();
  endtask

  task automatic check_div(input int d);
    pulse_q.delete();
    log_pulses = 1'b1;
    repeat (6 * (d + 1) + 6) tick();
    log_pulses = 1'b0;
    check("div_pulse_count", pulse_q.size() >= 6, 1'b1);
    for (int i = 1; i < pulse_q.size(); i++) check("div_period", pulse_q[i] - pulse_q[i-1], d + 1);
  endtask

  initial begin
    #900us;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [7:0]  v;
    for (int k = 0; k < NI; k++) m_in[k] = $urandom;
    repeat (3) tick();
    do_reset();

    // Write with exact two-cycle latency from the last byte
    cmd_q = {8'h01, 8'h02, 8'h78, 8'h56, 8'h34, 8'h12};
    issue_cmd();
    check("wr_latency_pre", out_bus[64 +: 32], 32'h0);
    tick();
    check("wr_latency_post", out_bus[64 +: 32], 32'h12345678);
    finish_cmd();

    // Atomic read reply under toggling tx_ready
    ready_mode = 1;
    m_in[1] = 32'hCAFEBABE;
    cmd_q = {8'h02, 8'h01};
    issue_cmd();
    tick();
    tick();
    m_in[1] = $urandom;
    m_in[0] = $urandom;
    finish_cmd();

    // Divided, halted and free-running clock enable
    ready_mode = 0;
    cmd_q = {8'h03, 8'h03, 8'h00, 8'h00, 8'h00}; run_cmd();
    cmd_q = {8'h04, 8'h02}; run_cmd();
    check_div(3);
    cmd_q = {8'h04, 8'h00}; run_cmd();
    en_cnt = 0;
    repeat (40) tick();
    check("halt_no_pulse", en_cnt, 0);
    cmd_q = {8'h04, 8'h01}; run_cmd();
    en_cnt = 0;
    repeat (20) tick();
    check("run_every_cycle", en_cnt, 20);
    cmd_q = {8'h05, 8'h05}; run_cmd();
    en_cnt = 0;
    repeat (10) tick();
    check("run_kept_after_nak", en_cnt, 10);

    // Single-step boundaries
    cmd_q = {8'h04, 8'h00}; run_cmd();
    cmd_q = {8'h05, 8'h05}; run_cmd();
    cmd_q = {8'h05, 8'h00}; run_cmd();
    cmd_q = {8'h05, 8'hFF}; run_cmd();

    // A byte arriving mid-step must be dropped
    cmd_q = {8'h05, 8'h14};
    issue_cmd();
    repeat (3) tick();
    send_byte(8'h7F, 0);
    finish_cmd();

    // Bad opcode and out-of-range write index
    ready_mode = 1;
    cmd_q = {8'h7F}; run_cmd();
    cmd_q = {8'h01, 8'h09, 8'h11, 8'h22, 8'h33, 8'h44}; run_cmd();
    cmd_q = {8'h02, 8'h02}; run_cmd();
    cmd_q = {8'h04, 8'h03}; run_cmd();

    // Lowering the divider below the live counter
    ready_mode = 0;
    cmd_q = {8'h03, 8'hC8, 8'h00, 8'h00, 8'h00}; run_cmd();
    cmd_q = {8'h04, 8'h02}; run_cmd();
    repeat (60) tick();
    cmd_q = {8'h03, 8'h02, 8'h00, 8'h00, 8'h00}; run_cmd();
    check_div(2);
    cmd_q = {8'h03, 8'h00, 8'h00, 8'h00, 8'h00}; run_cmd();
    check_div(0);
    cmd_q = {8'h04, 8'h00}; run_cmd();

    for (int it = 0; it < 30; it++) begin
      ready_mode = int'($urandom_range(0, 1));
      d = $urandom;
      case ($urandom_range(0, 5))
        0, 1: begin
          v = 8'($urandom_range(0, 5));
          cmd_q = {8'h01, v, d[7:0], d[15:8], d[23:16], d[31:24]};
          run_cmd();
        end
        2: begin
          for (int k = 0; k < NI; k++) m_in[k] = $urandom;
          v = 8'($urandom_range(0, 3));
          cmd_q = {8'h02, v};
          issue_cmd();
          tick();
          tick();
          for (int k = 0; k < NI; k++) m_in[k] = $urandom;
          finish_cmd();
        end
        3: begin
          v = 8'($urandom_range(5, 255));
          if (v == 8'h05) v = 8'h00;
          cmd_q = {v};
          run_cmd();
        end
        4: begin
          v = 8'($urandom_range(0, 3));
          cmd_q = {8'h04, v};
          run_cmd();
        end
        default: begin
          v = 8'($urandom_range(0, 12));
          cmd_q = {8'h05, v};
          run_cmd();
        end
      endcase
    end
    ready_mode = 0;
    cmd_q = {8'h04, 8'h00}; run_cmd();

    // Reset during a stalled read reply, then during a long step
    ready_mode = 2;
    cmd_q = {8'h02, 8'h01};
    issue_cmd();
    repeat (4) tick();
    check("rd_stalled_valid", tx_valid, 1'b1);
    do_reset();
    ready_mode = 0;
    cmd_q = {8'h05, 8'hFF};
    issue_cmd();
    repeat (20) tick();
    check("mid_step_clk_en", core_clk_en, 1'b1);
    do_reset();
    cmd_q = {8'h01, 8'h03, 8'hEF, 8'hBE, 8'hAD, 8'hDE}; run_cmd();
    cmd_q = {8'h02, 8'h00}; run_cmd();

    repeat (5) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
